// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and constants for the commit trace buffer: register-address width,
// overflow counter sizing, FIFO operation encoding and entry width helper.
package commit_trace_buffer_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned OVF_W      = 16;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  // Encoded as {read_advance, write_enable}
  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_SWAP = 2'b11
  } fifo_op_e;

  // Entry layout, MSB to LSB: {pc, rd, data, seq}
  function automatic int unsigned entry_w(input int unsigned xlen, input int unsigned seq_w);
    return 2 * xlen + REG_ADDR_W + seq_w;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Generic first-word-fall-through synchronous FIFO with optional evict-oldest-on-full.
// Storage is not reset; the read port shows the head entry whenever count is non-zero.
module commit_trace_buffer_fifo
  import commit_trace_buffer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter bit          OVERWRITE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  logic     pop_ok_c;
  logic     wr_en_c;
  logic     rd_adv_c;
  fifo_op_e op_c;

  // Push/pop resolution; a full FIFO with a concurrent pop always accepts the push
  always_comb begin
    pop_ok_c     = pop_i & ~empty_q;
    wr_en_c      = push_i & (~full_q | pop_ok_c | OVERWRITE);
    rd_adv_c     = pop_ok_c | (push_i & full_q & OVERWRITE);
    overflow_c_o = push_i & full_q & ~pop_ok_c;
    op_c         = fifo_op_e'({rd_adv_c, wr_en_c});

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_adv_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case (op_c)
        FIFO_PUSH: count_d = count_q + CW'(1);
        FIFO_POP:  count_d = count_q - CW'(1);
        default:   count_d = count_q;
      endcase
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c && !clear_i) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Snoops the core writeback port and queues retired writes to watched registers
// (pc, rd, data, sequence number) for a valid/ready debug drain. No effect on the core.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] WATCH_MASK = 32'h0000_003E,
  parameter bit          OVERWRITE  = 1'b0,
  parameter int unsigned SEQ_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   commit_valid,
  input  logic                   commit_we,
  input  logic [REG_ADDR_W-1:0]  commit_rd,
  input  logic [XLEN-1:0]        commit_pc,
  input  logic [XLEN-1:0]        commit_wdata,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [XLEN-1:0]        trace_pc,
  output logic [REG_ADDR_W-1:0]  trace_rd,
  output logic [XLEN-1:0]        trace_data,
  output logic [SEQ_W-1:0]       trace_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [OVF_W-1:0]       overflow_cnt
);

  localparam int unsigned EW       = entry_w(XLEN, SEQ_W);
  localparam int unsigned DATA_LSB = SEQ_W;
  localparam int unsigned RD_LSB   = DATA_LSB + XLEN;
  localparam int unsigned PC_LSB   = RD_LSB + REG_ADDR_W;

  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  logic          hit_c;
  logic          push_c;
  logic          overflow_c;
  logic [EW-1:0] wentry_c;
  logic [EW-1:0] rentry_c;
  logic [EW-1:0] head_c;
  logic          fifo_empty;

  // Capture qualification and sequence/overflow bookkeeping; clear wins over everything
  always_comb begin
    hit_c    = enable & commit_valid & commit_we & (commit_rd != '0) & WATCH_MASK[commit_rd];
    push_c   = hit_c & ~clear;
    wentry_c = {commit_pc, commit_rd, commit_wdata, seq_q};
    seq_d    = seq_q;
    ovf_d    = ovf_q;

    if (clear) begin
      seq_d = '0;
      ovf_d = '0;
    end else begin
      if (hit_c) begin
        seq_d = seq_q + SEQ_W'(1);
      end
      if (overflow_c && (ovf_q != OVF_MAX)) begin
        ovf_d = ovf_q + OVF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q <= '0;
      ovf_q <= '0;
    end else begin
      seq_q <= seq_d;
      ovf_q <= ovf_d;
    end
  end

  commit_trace_buffer_fifo #(
    .WIDTH     (EW),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (clear),
    .push_i       (push_c),
    .pop_i        (trace_ready),
    .wdata_i      (wentry_c),
    .rdata_o      (rentry_c),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (fifo_empty),
    .overflow_c_o (overflow_c)
  );

  // Unwritten storage may be X; the head is forced to zero whenever the FIFO is empty
  assign head_c = rentry_c & {EW{~fifo_empty}};

  assign trace_valid  = ~fifo_empty;
  assign empty        = fifo_empty;
  assign trace_pc     = head_c[PC_LSB +: XLEN];
  assign trace_rd     = head_c[RD_LSB +: REG_ADDR_W];
  assign trace_data   = head_c[DATA_LSB +: XLEN];
  assign trace_seq    = head_c[SEQ_W-1:0];
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: a drop-on-full and an evict-oldest instance (DEPTH=4)
// share stimulus; queue models per instance predict head, count and overflow.
module tb_commit_trace_buffer;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [15:0] seq;
  } ent_t;

  typedef struct {
    logic        en;
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    bit          hit;
    int unsigned cnt;
  } vec_t;

  localparam int unsigned MDEPTH = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        commit_valid;
  logic        commit_we;
  logic [4:0]  commit_rd;
  logic [31:0] commit_pc;
  logic [31:0] commit_wdata;
  logic        trace_ready;

  logic        d0_valid, d1_valid;
  logic [31:0] d0_pc, d1_pc, d0_data, d1_data;
  logic [4:0]  d0_rd, d1_rd;
  logic [15:0] d0_seq, d1_seq;
  logic [2:0]  d0_count, d1_count;
  logic        d0_full, d1_full, d0_empty, d1_empty;
  logic [15:0] d0_ovf, d1_ovf;

  ent_t        exp0[$];
  ent_t        exp1[$];
  logic [15:0] mseq;
  logic [15:0] ovf0, ovf1;

  int n_chk;
  int n_fail;

  vec_t tbl[13];

  commit_trace_buffer #(
    .XLEN(32), .DEPTH(4), .WATCH_MASK(32'h0000_003E), .OVERWRITE(1'b0), .SEQ_W(16)
  ) u_drop (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_pc(commit_pc), .commit_wdata(commit_wdata),
    .trace_valid(d0_valid), .trace_ready(trace_ready),
    .trace_pc(d0_pc), .trace_rd(d0_rd), .trace_data(d0_data), .trace_seq(d0_seq),
    .count(d0_count), .full(d0_full), .empty(d0_empty), .overflow_cnt(d0_ovf)
  );

  commit_trace_buffer #(
    .XLEN(32), .DEPTH(4), .WATCH_MASK(32'h0000_003E), .OVERWRITE(1'b1), .SEQ_W(16)
  ) u_evict (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_pc(commit_pc), .commit_wdata(commit_wdata),
    .trace_valid(d1_valid), .trace_ready(trace_ready),
    .trace_pc(d1_pc), .trace_rd(d1_rd), .trace_data(d1_data), .trace_seq(d1_seq),
    .count(d1_count), .full(d1_full), .empty(d1_empty), .overflow_cnt(d1_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_entry(input string name, input ent_t act, input ent_t exp);
    chk({name, ".pc"},   64'(act.pc),   64'(exp.pc));
    chk({name, ".rd"},   64'(act.rd),   64'(exp.rd));
    chk({name, ".data"}, 64'(act.data), 64'(exp.data));
    chk({name, ".seq"},  64'(act.seq),  64'(exp.seq));
  endtask

  function automatic ent_t head0();
    ent_t e;
    e.pc = d0_pc; e.rd = d0_rd; e.data = d0_data; e.seq = d0_seq;
    return e;
  endfunction

  function automatic ent_t head1();
    ent_t e;
    e.pc = d1_pc; e.rd = d1_rd; e.data = d1_data; e.seq = d1_seq;
    return e;
  endfunction

  task automatic model_reset();
    exp0.delete();
    exp1.delete();
    mseq = '0;
    ovf0 = '0;
    ovf1 = '0;
  endtask

  // Compare both instances against their queue models
  task automatic check_state();
    ent_t z;
    z = '{pc: '0, rd: '0, data: '0, seq: '0};
    chk("count0", 64'(d0_count), 64'(exp0.size()));
    chk("valid0", 64'(d0_valid), 64'(exp0.size() != 0));
    chk("full0",  64'(d0_full),  64'(exp0.size() == MDEPTH));
    chk("empty0", 64'(d0_empty), 64'(exp0.size() == 0));
    chk("ovf0",   64'(d0_ovf),   64'(ovf0));
    chk_entry("head0", head0(), (exp0.size() != 0) ? exp0[0] : z);
    chk("count1", 64'(d1_count), 64'(exp1.size()));
    chk("valid1", 64'(d1_valid), 64'(exp1.size() != 0));
    chk("full1",  64'(d1_full),  64'(exp1.size() == MDEPTH));
    chk("empty1", 64'(d1_empty), 64'(exp1.size() == 0));
    chk("ovf1",   64'(d1_ovf),   64'(ovf1));
    chk_entry("head1", head1(), (exp1.size() != 0) ? exp1[0] : z);
  endtask

  // Drive one cycle from a negedge; update models with pre-edge state, sample at next negedge
  task automatic step(input logic en, input logic v, input logic we, input logic [4:0] rd,
                      input logic [31:0] pc, input logic [31:0] data,
                      input logic rdy, input logic clr, input bit hit);
    ent_t e;
    enable = en; commit_valid = v; commit_we = we; commit_rd = rd;
    commit_pc = pc; commit_wdata = data; trace_ready = rdy; clear = clr;
    if (clr) begin
      model_reset();
    end else begin
      if (rdy && exp0.size() != 0) begin
        chk_entry("pop0", head0(), exp0[0]);
        void'(exp0.pop_front());
      end
      if (rdy && exp1.size() != 0) begin
        chk_entry("pop1", head1(), exp1[0]);
        void'(exp1.pop_front());
      end
      if (hit) begin
        e = '{pc: pc, rd: rd, data: data, seq: mseq};
        if (exp0.size() < MDEPTH) exp0.push_back(e);
        else if (ovf0 != 16'hFFFF) ovf0++;
        if (exp1.size() == MDEPTH) begin
          void'(exp1.pop_front());
          if (ovf1 != 16'hFFFF) ovf1++;
        end
        exp1.push_back(e);
        mseq++;
      end
    end
    @(negedge clk);
    enable = 1'b0; commit_valid = 1'b0; commit_we = 1'b0; commit_rd = '0;
    commit_pc = '0; commit_wdata = '0; trace_ready = 1'b0; clear = 1'b0;
    check_state();
  endtask

  task automatic do_hit(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] data,
                        input logic rdy);
    step(1'b1, 1'b1, 1'b1, rd, pc, data, rdy, 1'b0, 1'b1);
  endtask

  task automatic do_idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    enable = 1'b0; clear = 1'b0; commit_valid = 1'b0; commit_we = 1'b0;
    commit_rd = '0; commit_pc = '0; commit_wdata = '0; trace_ready = 1'b0;
    model_reset();

    //          en v  we rd     pc          data    rdy clr hit cnt
    tbl[0]  = '{1, 1, 1, 5'd1, 32'h0,  32'd5, 0, 0, 1, 1};
    tbl[1]  = '{1, 1, 1, 5'd2, 32'h4,  32'd7, 0, 0, 1, 2};
    tbl[2]  = '{1, 1, 1, 5'd0, 32'h8,  32'd9, 0, 0, 0, 2};
    tbl[3]  = '{0, 0, 0, 5'd0, 32'h0,  32'd0, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 5'd0, 32'h0,  32'd0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 5'd0, 32'h0,  32'd0, 1, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 5'd1, 32'hC,  32'd4, 0, 1, 0, 0};
    tbl[7]  = '{1, 1, 1, 5'd6, 32'h10, 32'd1, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 5'd3, 32'h14, 32'd3, 0, 0, 1, 1};
    tbl[9]  = '{0, 1, 1, 5'd1, 32'h18, 32'd8, 0, 0, 0, 1};
    tbl[10] = '{1, 1, 0, 5'd2, 32'h1C, 32'd8, 0, 0, 0, 1};
    tbl[11] = '{1, 0, 1, 5'd3, 32'h20, 32'd8, 0, 0, 0, 1};
    tbl[12] = '{1, 1, 1, 5'd5, 32'h24, 32'hAB, 0, 0, 1, 2};

    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_state();

    // Table: basic capture, x0/unwatched filtering, drain, clear-vs-hit, qualifier gating
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].we, tbl[i].rd, tbl[i].pc, tbl[i].data,
           tbl[i].rdy, tbl[i].clr, tbl[i].hit);
      chk($sformatf("tbl%0d.count", i), 64'(d0_count), 64'(tbl[i].cnt));
    end
    chk("tbl_x3_seq", 64'(d0_seq), 64'd0);
    chk("tbl_x3_rd",  64'(d0_rd),  64'd3);

    // Overflow: six hits into DEPTH=4 with no drain
    do_clear();
    for (int i = 0; i < 6; i++) begin
      do_hit(5'(1 + (i % 5)), 32'(i * 4), 32'(100 + i), 1'b0);
    end
    chk("ovfl_drop_cnt",   64'(d0_ovf),   64'd2);
    chk("ovfl_evict_cnt",  64'(d1_ovf),   64'd2);
    chk("ovfl_drop_count", 64'(d0_count), 64'd4);
    chk("ovfl_drop_head",  64'(d0_seq),   64'd0);
    chk("ovfl_evict_head", 64'(d1_seq),   64'd2);
    for (int i = 0; i < 4; i++) do_idle(1'b1);
    chk("ovfl_drained", 64'(d1_empty), 64'd1);

    // Full FIFO with simultaneous hit and pop
    do_clear();
    for (int i = 0; i < 4; i++) do_hit(5'(1 + i), 32'(i * 4), 32'(200 + i), 1'b0);
    chk("full_before", 64'(d0_full), 64'd1);
    do_hit(5'd5, 32'h40, 32'd250, 1'b1);
    chk("full_swap_count", 64'(d0_count), 64'd4);
    chk("full_swap_ovf",   64'(d0_ovf),   64'd0);
    chk("full_swap_head",  64'(d0_seq),   64'd1);
    for (int i = 0; i < 5; i++) do_idle(1'b1);

    // Asynchronous reset mid-stream, then clear during a hit
    do_clear();
    for (int i = 0; i < 3; i++) do_hit(5'(2 + i), 32'(i * 4), 32'(300 + i), 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_state();
    chk("rst_valid", 64'(d0_valid), 64'd0);
    chk("rst_pc",    64'(d0_pc),    64'd0);
    @(negedge clk);
    reset = 1'b1;
    check_state();
    for (int i = 0; i < 5; i++) do_hit(5'(1 + i), 32'(i * 4), 32'(400 + i), 1'b0);
    chk("pre_clear_ovf", 64'(d0_ovf), 64'd1);
    step(1'b1, 1'b1, 1'b1, 5'd1, 32'h80, 32'd1, 1'b0, 1'b1, 1'b0);
    chk("clr_empty", 64'(d0_empty), 64'd1);
    chk("clr_ovf",   64'(d0_ovf),   64'd0);
    do_hit(5'd2, 32'h84, 32'd2, 1'b0);
    chk("clr_next_seq", 64'(d0_seq), 64'd0);
    do_idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
